// File: rtl/pe_mac_if.sv
// Operand/result bundle for one pe_mac processing element.
// The master drives the operands and receives the registered partial sum.
interface pe_mac_if #(
    parameter int unsigned weightPar       = 8,
    parameter int unsigned accumulationPar = 32
);
    logic [weightPar-1:0]       activation;
    logic [weightPar-1:0]       weight;
    logic [accumulationPar-1:0] inPartialSum;
    logic [accumulationPar-1:0] outPartialSum;

    modport master (
        output activation,
        output weight,
        output inPartialSum,
        input  outPartialSum
    );

    modport slave (
        input  activation,
        input  weight,
        input  inPartialSum,
        output outPartialSum
    );
endinterface

// File: rtl/pe_mac.sv
// Two-stage signed multiply-accumulate PE: outPartialSum = inPartialSum + activation*weight.
// Optional saturating accumulate when PE_SATURATE_EN is defined; the default build wraps.
module pe_mac #(
    parameter int unsigned weightPar       = 8,
    parameter int unsigned accumulationPar = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    pe_mac_if.slave     bus
);
    localparam int unsigned PROD_W = 2 * weightPar;
    localparam int unsigned ACC_W  = accumulationPar;

    logic signed [PROD_W-1:0] act_ext_c;
    logic signed [PROD_W-1:0] wgt_ext_c;
    logic signed [PROD_W-1:0] prod_c;
    logic signed [PROD_W-1:0] prod_q;
    logic signed [ACC_W-1:0]  psum_q;
    logic signed [ACC_W-1:0]  prod_ext_c;
    logic signed [ACC_W-1:0]  sum_wrap_c;
    logic signed [ACC_W-1:0]  sum_c;
    logic signed [ACC_W-1:0]  out_q;

    // Operands widened to the full product width so the multiply is exact.
    assign act_ext_c = PROD_W'($signed(bus.activation));
    assign wgt_ext_c = PROD_W'($signed(bus.weight));
    assign prod_c    = act_ext_c * wgt_ext_c;

    // Stage 1: product and delay-matched incoming partial sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            psum_q <= '0;
        end else begin
            prod_q <= prod_c;
            psum_q <= $signed(bus.inPartialSum);
        end
    end

    assign prod_ext_c = ACC_W'(prod_q);
    assign sum_wrap_c = prod_ext_c + psum_q;

`ifdef PE_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic ovf_c;

    // Overflow only when both addends share a sign that the wrapped sum loses.
    assign ovf_c = (prod_ext_c[ACC_W-1] == psum_q[ACC_W-1]) &&
                   (sum_wrap_c[ACC_W-1] != psum_q[ACC_W-1]);

    always_comb begin
        sum_c = sum_wrap_c;
        if (ovf_c) begin
            sum_c = psum_q[ACC_W-1] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    always_comb begin
        sum_c = sum_wrap_c;
    end
`endif

    // Stage 2: registered accumulate result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= sum_c;
        end
    end

    assign bus.outPartialSum = out_q;

endmodule

// File: tb/tb_pe_mac.sv
// Scoreboard bench for pe_mac: directed corners plus randomized triples against an integer model.
module tb_pe_mac;
    localparam int unsigned WP = 8;
    localparam int unsigned AW = 32;

    typedef struct {
        int unsigned   tag;
        logic [AW-1:0] exp;
        string         name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    exp_t        sb_q[$];
    exp_t        mon_e;

    pe_mac_if #(.weightPar(WP), .accumulationPar(AW)) bus ();

    pe_mac #(.weightPar(WP), .accumulationPar(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: exact integer arithmetic, then wrap or clamp to AW bits.
    function automatic logic [AW-1:0] model(input int a, input int w, input logic [AW-1:0] p);
        longint s;
        longint smax;
        longint smin;
        logic [63:0] s_bits;
        s    = longint'($signed(p)) + longint'(a) * longint'(w);
        smax = (longint'(1) <<< (AW - 1)) - 1;
        smin = -(longint'(1) <<< (AW - 1));
`ifdef PE_SATURATE_EN
        if (s > smax) s = smax;
        if (s < smin) s = smin;
`endif
        s_bits = s;
        return s_bits[AW-1:0];
    endfunction

    function automatic void push(input int unsigned tag, input logic [AW-1:0] exp, input string name);
        exp_t e;
        e.tag  = tag;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
    endfunction

    // Drive one triple for one cycle; its result is due two edges later.
    task automatic issue(input int a, input int w, input logic [AW-1:0] p, input string name);
        bus.activation   = WP'(a);
        bus.weight       = WP'(w);
        bus.inPartialSum = p;
        push(cyc + 2, model(a, w, p), name);
        @(posedge clk);
        #1;
    endtask

    // Reset discards everything in flight; output reads zero until fresh data arrives.
    task automatic hold_reset(input int n);
        rst_n = 1'b0;
        while (sb_q.size() > 0 && sb_q[$].tag >= cyc) void'(sb_q.pop_back());
        for (int i = 0; i < n; i++) begin
            bus.activation   = WP'($urandom_range(1, 100));
            bus.weight       = WP'($urandom_range(1, 100));
            bus.inPartialSum = AW'($urandom_range(1, 1000));
            push(cyc, '0, "reset_low");
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        push(cyc, '0, "post_reset0");
        push(cyc + 1, '0, "post_reset1");
    endtask

    // Monitor: compare every due scoreboard entry at the falling edge.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].tag <= cyc) begin
            mon_e = sb_q.pop_front();
            checks++;
            if (mon_e.tag < cyc) begin
                failures++;
                $display("FAIL %s: result for cycle %0d never checked (now %0d)", mon_e.name, mon_e.tag, cyc);
            end else if (bus.outPartialSum !== mon_e.exp) begin
                failures++;
                $display("FAIL %s: cycle %0d got 0x%h expected 0x%h", mon_e.name, cyc, bus.outPartialSum, mon_e.exp);
            end
        end
    end

    initial begin
        int a;
        int w;
        logic [AW-1:0] p;
        int sel;

        bus.activation   = '0;
        bus.weight       = '0;
        bus.inPartialSum = '0;
        @(posedge clk);
        #1;

        // Reset with nonzero inputs, then first operation.
        hold_reset(3);
        issue(3, 4, 32'd10, "first_op");

        // Signed operands and corners.
        issue(-2, 5, 32'd0, "neg_times_pos");
        issue(-128, -128, 32'd0, "min_times_min");
        issue(127, 127, 32'hFFFF_FFFF, "max_times_max");
        issue(0, 77, 32'h1234_5678, "zero_operand");

        // Back-to-back pipelining.
        issue(1, 1, 32'd0, "b2b_0");
        issue(2, 3, 32'd1, "b2b_1");
        issue(0, 100, 32'd7, "b2b_2");
        issue(-1, -1, 32'd5, "b2b_3");

        // Accumulator overflow in both directions.
        issue(1, 1, 32'h7FFF_FFFF, "pos_overflow");
        issue(-1, 1, 32'h8000_0000, "neg_overflow");
        issue(-128, 127, 32'h8000_0000, "neg_overflow_big");
        issue(-128, -128, 32'h7FFF_FFF0, "pos_overflow_big");

        // Reset between the first and second edge of an operation.
        issue(10, 10, 32'd5, "pre_midreset");
        hold_reset(2);
        issue(2, 2, 32'd2, "after_midreset");
        issue(2, 2, 32'd2, "after_midreset_hold");

        // Randomized triples, each held three cycles, corners mixed in.
        for (int k = 0; k < 1000; k++) begin
            sel = int'($urandom_range(0, 7));
            a   = (sel == 0) ? -128 : (sel == 1) ? 127 : int'($urandom_range(0, 255)) - 128;
            sel = int'($urandom_range(0, 7));
            w   = (sel == 0) ? -128 : (sel == 1) ? 127 : int'($urandom_range(0, 255)) - 128;
            sel = int'($urandom_range(0, 7));
            p   = (sel == 0) ? 32'h7FFF_FFFF : (sel == 1) ? 32'h8000_0000 : AW'($urandom);
            repeat (3) issue(a, w, p, "random");
        end

        // Drain remaining expectations with a bounded wait.
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (sb_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d results still pending, expected 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pe_mac.md
Name: pe_mac

Overview:
- Single multiply-accumulate processing element for the systolic/array datapath of the CNN accelerator.
- Each cycle it takes an activation, a weight and an incoming partial sum, and produces `inPartialSum + activation*weight`.
- Fully pipelined: 2-cycle latency, one new operation accepted per clock.
- Instances chain `outPartialSum` into the next PE's `inPartialSum`.

Parameters:
- accumulationPar, 32, width of partial-sum input/output and accumulator (bits); legal range ≥ 2*weightPar.
- weightPar, 8, width of activation and weight operands (bits); legal range ≥ 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- activation  input  weightPar  activation operand, signed two's complement.
- weight  input  weightPar  weight operand, signed two's complement.
- inPartialSum  input  accumulationPar  incoming partial sum, signed two's complement.
- outPartialSum  output  accumulationPar  registered result, signed two's complement.

Behaviour:
- Reset: `rst_n`=0 asynchronously clears all pipeline registers; `outPartialSum`=0 while `rst_n` is low and until a valid result reaches the output stage.
  - Assertion mid-operation discards all in-flight results immediately.
  - After deassertion, inputs are sampled starting at the first rising edge.
- Stage 1, rising edge N:
  - register product P = activation*weight as a full-precision signed 2*weightPar-bit value.
  - register inPartialSum alongside P (delay-matched).
- Stage 2, rising edge N+1:
  - outPartialSum <= sign_extend(P, accumulationPar) + registered inPartialSum.
- Latency: inputs sampled at edge N appear on outPartialSum after edge N+1 and stay stable until edge N+2.
- Throughput: 1 operation/cycle, no stall or handshake. Inputs held constant produce a constant output after 2 edges.
- Arithmetic:
  - Multiplication is exact (no overflow possible in 2*weightPar bits).
  - Default (no macro) addition wraps modulo 2^accumulationPar.
- No enable, no clear other than rst_n. The output is purely a function of the inputs from 2 edges earlier.
- Corner operands must be exact:
  - activation = weight = -2^(weightPar-1) gives +2^(2*weightPar-2).
  - 0 times anything gives inPartialSum unchanged.

Optional Feature:
- Macro: PE_SATURATE_EN.
- When defined, stage 2 uses a saturating signed add:
  - positive overflow clamps to 2^(accumulationPar-1)-1.
  - negative overflow clamps to -2^(accumulationPar-1).
  - Overflow is detected when both addends have the same sign and the sum sign differs.
  - Latency unchanged (2 cycles).
- When not defined: wrap-around addition as above; no saturation logic is synthesized.

Test Plan:
1. Reset → hold `rst_n`=0 with nonzero inputs for 3 edges → outPartialSum = 0x00000000; release, apply act=3, w=4, in=10 → 22 (0x00000016) after 2 edges.
2. Signed operands → act=-2 (0xFE), w=5, in=0 → 0xFFFFFFF6 (-10); act=-128, w=-128, in=0 → 0x00004000 (16384); act=127, w=127, in=-1 → 0x00003F00 (16128).
3. Back-to-back pipelining → change inputs every cycle: (1,1,0), (2,3,1), (0,100,7), (-1,-1,5) → outputs 1, 7, 7, 6 on consecutive cycles, each exactly 2 edges after its inputs.
4. Overflow → act=1, w=1, in=0x7FFFFFFF → 0x80000000 without PE_SATURATE_EN; 0x7FFFFFFF with it. act=-1, w=1, in=0x80000000 → 0x7FFFFFFF without it; 0x80000000 with it.
5. Reset mid-operation → apply act=10, w=10, in=5, assert `rst_n` low between edges 1 and 2 → output 0 immediately and stays 0 while low; after release, new inputs (2,2,2) → 6 after 2 edges, no stale 105.
6. File-driven random regression → 1000 random signed triples, each held 3 cycles and sampled at the falling edge after the 2nd edge → matches a golden model computing `in + act*w` modulo 2^32 (or saturated when PE_SATURATE_EN is defined).
